// File: rtl/qbus_dl11_console_if.sv
// Q-bus (1801VM1 MPI) pin bundle for the DL11 console slave.
// The CPU/pad side drives strobes and AD inputs; the device drives read data and reply.
interface qbus_dl11_console_if;
  logic [15:0] ad_in_n;
  logic [15:0] ad_out_n;
  logic        ad_oe;
  logic        sync_n;
  logic        din_n;
  logic        dout_n;
  logic        wtbt_n;
  logic [1:0]  sel_n;
  logic        rply_oe;

  modport master (
    output ad_in_n, sync_n, din_n, dout_n, wtbt_n, sel_n,
    input  ad_out_n, ad_oe, rply_oe
  );

  modport slave (
    input  ad_in_n, sync_n, din_n, dout_n, wtbt_n, sel_n,
    output ad_out_n, ad_oe, rply_oe
  );
endinterface

// File: rtl/qbus_dl11_console.sv
// DL11-style console: relocatable RCSR/RBUF/XCSR/XBUF block on the VM1 Q-bus,
// with RX/TX byte FIFOs toward the host and level interrupt requests.
module qbus_dl11_console #(
  parameter logic [15:0] BASE_ADDR = 16'o177560,
  parameter int unsigned RX_DEPTH  = 4,
  parameter int unsigned TX_DEPTH  = 4,
  parameter int unsigned RPLY_DLY  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_n,
  qbus_dl11_console_if.slave      bus,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    rx_irq,
  output logic                    tx_irq
);

  localparam int unsigned RAW = $clog2(RX_DEPTH);
  localparam int unsigned TAW = $clog2(TX_DEPTH);
  localparam int unsigned RCW = RAW + 1;
  localparam int unsigned TCW = TAW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_RPLY,
    S_DONE
  } state_t;

  logic reset;
  assign reset = ~rst_n | ~init_n;

  state_t      state;
  logic        sync_q;
  logic [1:0]  reg_q;
  logic        a0_q;
  logic        rd_q;
  logic        byte_q;
  logic [7:0]  wdata_q;
  logic [3:0]  cnt;
  logic        ad_oe_q;
  logic        rply_q;
  logic [15:0] ad_out_q;

  logic        rie;
  logic        xie;
  logic        ovr;

  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_rd;
  logic [RAW-1:0] rx_wr;
  logic [RCW-1:0] rx_cnt;
  logic           rx_ne;
  logic           rx_full;
  logic           rx_push;
  logic           rx_pop;
  logic [7:0]     rx_head;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_rd;
  logic [TAW-1:0] tx_wr;
  logic [TCW-1:0] tx_cnt;
  logic           tx_full;
  logic           tx_push;
  logic           tx_pop;

  logic [15:0] a_in;
  logic        hit;
  logic        strobe;
  logic        wr_fire;
  logic        rbuf_pop;
  logic [15:0] rd_word;

  assign a_in   = ~bus.ad_in_n;
  assign hit    = (bus.sel_n == 2'b11) && (a_in[15:3] == BASE_ADDR[15:3]);
  assign strobe = ~bus.din_n | ~bus.dout_n;

  // Side effects fire only on a live cycle; an abandoned cycle (sync_n up) does nothing.
  assign wr_fire  = ~reset && (state == S_WAIT) && (cnt == 4'd0) && ~rd_q &&
                    ~bus.sync_n && ~(byte_q && a0_q);
  assign rbuf_pop = ~reset && (state == S_RPLY) && rd_q && bus.din_n &&
                    ~bus.sync_n && (reg_q == 2'd1);

  assign rx_ne   = (rx_cnt != '0);
  assign rx_full = (rx_cnt == RCW'(RX_DEPTH));
  assign rx_pop  = rbuf_pop && rx_ne;
  assign rx_push = rx_valid && (~rx_full || rx_pop);
  assign rx_head = rx_ne ? rx_mem[rx_rd] : '0;

  assign tx_full  = (tx_cnt == TCW'(TX_DEPTH));
  assign tx_valid = (tx_cnt != '0);
  assign tx_data  = tx_mem[tx_rd];
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = wr_fire && (reg_q == 2'd3) && (~tx_full || tx_pop);

  assign rx_irq = rie & rx_ne;
  assign tx_irq = xie & ~tx_full;

  assign bus.ad_oe    = ad_oe_q;
  assign bus.ad_out_n = ad_out_q;
  assign bus.rply_oe  = rply_q;

  always_comb begin
    rd_word = '0;
    case (reg_q)
      2'd0:    rd_word[7:6] = {rx_ne, rie};
      2'd1:    rd_word      = {ovr, ovr, 6'b0, rx_head};
      2'd2:    rd_word[7:6] = {~tx_full, xie};
      default: rd_word      = '0;
    endcase
  end

  // Bus slave FSM; read data is launched on WAIT entry so status is a snapshot of that clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      sync_q   <= 1'b1;
      reg_q    <= '0;
      a0_q     <= 1'b0;
      rd_q     <= 1'b0;
      byte_q   <= 1'b0;
      wdata_q  <= '0;
      cnt      <= '0;
      ad_oe_q  <= 1'b0;
      rply_q   <= 1'b0;
      ad_out_q <= '1;
    end else begin
      sync_q <= bus.sync_n;
      if (bus.sync_n && (state != S_IDLE)) begin
        state    <= S_IDLE;
        ad_oe_q  <= 1'b0;
        rply_q   <= 1'b0;
        ad_out_q <= '1;
      end else begin
        case (state)
          S_IDLE: begin
            if (~bus.sync_n && sync_q) begin
              reg_q <= a_in[2:1];
              a0_q  <= a_in[0];
              if (hit) state <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (strobe) begin
              rd_q    <= ~bus.din_n;
              byte_q  <= ~bus.wtbt_n;
              wdata_q <= a_in[7:0];
              cnt     <= 4'(RPLY_DLY);
              state   <= S_WAIT;
              if (~bus.din_n) begin
                ad_oe_q  <= 1'b1;
                ad_out_q <= ~rd_word;
              end
            end
          end
          S_WAIT: begin
            if (cnt == 4'd0) begin
              state  <= S_RPLY;
              rply_q <= 1'b1;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          S_RPLY: begin
            if ((rd_q && bus.din_n) || (~rd_q && bus.dout_n)) begin
              state    <= S_DONE;
              rply_q   <= 1'b0;
              ad_oe_q  <= 1'b0;
              ad_out_q <= '1;
            end
          end
          S_DONE: begin
            if (strobe) state <= S_ADDR;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rie <= 1'b0;
      xie <= 1'b0;
    end else if (wr_fire) begin
      if (reg_q == 2'd0) rie <= wdata_q[6];
      if (reg_q == 2'd2) xie <= wdata_q[6];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_rd  <= '0;
      rx_wr  <= '0;
      rx_cnt <= '0;
      ovr    <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      rx_cnt <= rx_cnt + RCW'(rx_push) - RCW'(rx_pop);
      if (rbuf_pop) ovr <= 1'b0;
      if (rx_valid && ~rx_push) ovr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_data;
    if (tx_push) tx_mem[tx_wr] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_rd  <= '0;
      tx_wr  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      tx_cnt <= tx_cnt + TCW'(tx_push) - TCW'(tx_pop);
    end
  end

endmodule

// File: tb/tb_qbus_dl11_console.sv
// Directed + randomized bench for qbus_dl11_console against a queue-based register model.
module tb_qbus_dl11_console;
  localparam int unsigned RXD = 4;
  localparam int unsigned TXD = 4;
  localparam int unsigned DLY = 1;
  localparam logic [15:0] RCSR = 16'o177560;
  localparam logic [15:0] RBUF = 16'o177562;
  localparam logic [15:0] XCSR = 16'o177564;
  localparam logic [15:0] XBUF = 16'o177566;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_n = 1'b1;
  always #5 clk = ~clk;

  qbus_dl11_console_if bus ();
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       rx_irq;
  logic       tx_irq;

  qbus_dl11_console #(
    .BASE_ADDR (16'o177560),
    .RX_DEPTH  (RXD),
    .TX_DEPTH  (TXD),
    .RPLY_DLY  (DLY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_n   (init_n),
    .bus      (bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_irq   (rx_irq),
    .tx_irq   (tx_irq)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] tx_got [$];

  always @(posedge clk)
    if (rst_n && init_n && tx_valid && tx_ready) tx_got.push_back(tx_data);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data,
                          output bit ok, output int lat);
    data = '0; ok = 1'b0; lat = 0;
    @(negedge clk);
    bus.ad_in_n = ~addr; bus.wtbt_n = 1'b1; bus.sync_n = 1'b0;
    @(negedge clk);
    bus.ad_in_n = '1; bus.din_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.rply_oe) begin ok = 1'b1; lat = i; break; end
    end
    if (ok) begin
      data = ~bus.ad_out_n;
      chk("rd_ad_oe", 16'(bus.ad_oe), 16'd1);
    end
    bus.din_n = 1'b1;
    @(negedge clk);
    if (ok) chk("rd_rply_release", 16'(bus.rply_oe), 16'd0);
    bus.sync_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data,
                           input bit is_byte, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.ad_in_n = ~addr; bus.wtbt_n = 1'b0; bus.sync_n = 1'b0;
    @(negedge clk);
    bus.ad_in_n = ~data; bus.wtbt_n = ~is_byte; bus.dout_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.rply_oe) begin ok = 1'b1; break; end
    end
    bus.dout_n = 1'b1;
    @(negedge clk);
    bus.sync_n = 1'b1; bus.wtbt_n = 1'b1; bus.ad_in_n = '1;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    logic [15:0] d; bit ok; int lat;
    bus_read(addr, d, ok, lat);
    chk({tag, "_rply"}, 16'(ok), 16'd1);
    chk(tag, d, exp);
  endtask

  task automatic wr_do(input string tag, input logic [15:0] addr, input logic [15:0] data,
                       input bit is_byte);
    bit ok;
    bus_write(addr, data, is_byte, ok);
    chk({tag, "_rply"}, 16'(ok), 16'd1);
  endtask

  task automatic host_push(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    bit ok;
    int lat;
    logic [7:0] b5 [5];
    logic [7:0] rx_q [$];
    logic [7:0] tx_exp [$];
    bit rie_m, xie_m, ovr_m;

    bus.ad_in_n = '1; bus.sync_n = 1'b1; bus.din_n = 1'b1;
    bus.dout_n = 1'b1; bus.wtbt_n = 1'b1; bus.sel_n = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 16'(tx_valid), 16'd0);
    chk("rst_rx_irq", 16'(rx_irq), 16'd0);
    chk("rst_tx_irq", 16'(tx_irq), 16'd0);
    chk("rst_ad_oe", 16'(bus.ad_oe), 16'd0);
    chk("rst_rply", 16'(bus.rply_oe), 16'd0);
    chk("rst_ad_out", bus.ad_out_n, 16'hFFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // strobe driven before sampling edge; rply seen RPLY_DLY+1 edges after that
    bus_read(RCSR, d, ok, lat);
    chk("rcsr_reset", d, 16'h0000);
    chk("rply_latency", 16'(lat), 16'(DLY + 2));
    rd_chk("xcsr_reset", XCSR, 16'h0080);

    tx_ready = 1'b1;
    wr_do("xbuf_word", XBUF, 16'h0141, 1'b0);
    repeat (3) @(negedge clk);
    chk("tx_one_beat", 16'(tx_got.size()), 16'd1);
    if (tx_got.size() > 0) chk("tx_beat_data", 16'(tx_got[0]), 16'h0041);
    wr_do("xbuf_odd", 16'o177567, 16'h4200, 1'b1);
    repeat (3) @(negedge clk);
    chk("tx_odd_no_beat", 16'(tx_got.size()), 16'd1);
    tx_got.delete();

    host_push(8'h55);
    host_push(8'hAA);
    rd_chk("rbuf_first", RBUF, 16'h0055);
    rd_chk("rbuf_second", RBUF, 16'h00AA);
    rd_chk("rcsr_done_fell", RCSR, 16'h0000);

    for (int i = 0; i < 5; i++) begin
      b5[i] = 8'($urandom);
      host_push(b5[i]);
    end
    rd_chk("rbuf_ovr", RBUF, {8'hC0, b5[0]});
    for (int i = 1; i < 4; i++) rd_chk("rbuf_after_ovr", RBUF, {8'h00, b5[i]});
    rd_chk("rcsr_drained", RCSR, 16'h0000);

    wr_do("rcsr_ie", RCSR, 16'h0040, 1'b0);
    chk("rx_irq_empty", 16'(rx_irq), 16'd0);
    host_push(8'h3C);
    @(negedge clk);
    chk("rx_irq_set", 16'(rx_irq), 16'd1);
    rd_chk("rcsr_done_ie", RCSR, 16'h00C0);
    rd_chk("rbuf_irq_byte", RBUF, 16'h003C);
    chk("rx_irq_clear", 16'(rx_irq), 16'd0);
    wr_do("xcsr_ie", XCSR, 16'h0040, 1'b0);
    chk("tx_irq_set", 16'(tx_irq), 16'd1);
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) wr_do("xbuf_fill", XBUF, 16'(i * 16'h11), 1'b0);
    chk("tx_irq_full", 16'(tx_irq), 16'd0);
    rd_chk("xcsr_full", XCSR, 16'h0040);
    chk("tx_valid_full", 16'(tx_valid), 16'd1);
    chk("tx_head_full", 16'(tx_data), 16'h0011);
    tx_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("tx_drain_count", 16'(tx_got.size()), 16'd4);
    for (int i = 0; i < 4 && i < tx_got.size(); i++)
      chk("tx_drain_data", 16'(tx_got[i]), 16'((i + 1) * 16'h11));
    chk("tx_irq_drained", 16'(tx_irq), 16'd1);
    tx_got.delete();

    host_push(8'h99);
    @(negedge clk);
    bus.ad_in_n = ~RBUF; bus.sync_n = 1'b0;
    @(negedge clk);
    bus.ad_in_n = '1; bus.din_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.rply_oe;
    end
    chk("abort_reached_rply", 16'(ok), 16'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rply", 16'(bus.rply_oe), 16'd0);
    chk("abort_ad_oe", 16'(bus.ad_oe), 16'd0);
    chk("abort_ad_out", bus.ad_out_n, 16'hFFFF);
    bus.din_n = 1'b1; bus.sync_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("abort_rcsr", RCSR, 16'h0000);
    chk("abort_tx_irq", 16'(tx_irq), 16'd0);

    bus_read(16'o177570, d, ok, lat);
    chk("timeout_177570", 16'(ok), 16'd0);

    rie_m = 1'b0; xie_m = 1'b0; ovr_m = 1'b0;
    for (int n = 0; n < 200; n++) begin
      logic [15:0] wd;
      bit isb, a0;
      logic [7:0] hb;
      wd = 16'($urandom);
      isb = 1'($urandom_range(0, 1));
      a0 = isb ? 1'($urandom_range(0, 1)) : 1'b0;
      case ($urandom_range(0, 6))
        0: begin
          hb = 8'($urandom);
          host_push(hb);
          if (rx_q.size() < RXD) rx_q.push_back(hb);
          else ovr_m = 1'b1;
        end
        1: begin
          hb = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
          rd_chk("rnd_rbuf", RBUF, {ovr_m, ovr_m, 6'b0, hb});
          if (rx_q.size() != 0) void'(rx_q.pop_front());
          ovr_m = 1'b0;
        end
        2: rd_chk("rnd_rcsr", RCSR, {8'h00, rx_q.size() != 0, rie_m, 6'b0});
        3: begin
          wr_do("rnd_wr_rcsr", RCSR | 16'(a0), wd, isb);
          if (!(isb && a0)) rie_m = wd[6];
        end
        4: begin
          wr_do("rnd_wr_xcsr", XCSR | 16'(a0), wd, isb);
          if (!(isb && a0)) xie_m = wd[6];
        end
        5: rd_chk("rnd_xcsr", XCSR, {8'h00, 1'b1, xie_m, 6'b0});
        default: begin
          wr_do("rnd_wr_xbuf", XBUF | 16'(a0), wd, isb);
          if (!(isb && a0)) tx_exp.push_back(wd[7:0]);
        end
      endcase
      chk("rnd_rx_irq", 16'(rx_irq), 16'(rie_m && rx_q.size() != 0));
      chk("rnd_tx_irq", 16'(tx_irq), 16'(xie_m));
    end
    repeat (6) @(negedge clk);
    chk("rnd_tx_count", 16'(tx_got.size()), 16'(tx_exp.size()));
    for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
      chk("rnd_tx_data", 16'(tx_got[i]), 16'(tx_exp[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/qbus_dl11_console.md
# qbus_dl11_console

Synthesizable DL11-style console serial device for the 1801VM1 MPI/Q-bus. It replaces the bench-only TPS/TPB reply logic with a real bus slave: a relocatable register block, receive and transmit FIFOs of configurable depth, configurable reply latency, and per-direction interrupt requests. The bus side connects to the VM1 bus pins through external tri-state pads. The host side is a byte stream to a UART, terminal model or simulation printer.

## Interface
- BASE_ADDR, 16'o177560: register block base; bits [2:0] ignored.
- RX_DEPTH, 4: receive FIFO depth; power of 2, ≥2.
- TX_DEPTH, 4: transmit FIFO depth; power of 2, ≥2.
- RPLY_DLY, 1: clocks from strobe detection to rply assertion; 0..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- init_n  in  1  bus INIT, active-low; same effect as rst_n.
- ad_in_n  in  16  bus AD lines, inverted.
- ad_out_n  out  16  read data, inverted; valid when ad_oe=1.
- ad_oe  out  1  drive ad_out_n onto bus.
- sync_n, din_n, dout_n, wtbt_n  in  1 each  bus strobes, active-low.
- sel_n  in  2  VM1 select; the device responds only when sel_n==2'b11.
- rply_oe  out  1  1 = pull rply_n low.
- rx_irq, tx_irq  out  1 each  level interrupt requests.
- rx_data  in  8, rx_valid  in  1  host→CPU byte, one byte per valid clock.
- tx_data  out  8, tx_valid  out  1, tx_ready  in  1  CPU→host stream; a byte transfers when valid&ready.

## Operation
- Address latch: on the first clk where sync_n is sampled low after being high, latch a=~ad_in_n and wr=~wtbt_n.
  - hit = sel_n==2'b11 && a[15:3]==BASE_ADDR[15:3].
  - reg = a[2:1].
- Registers (bits not listed read 0, writes ignored):
  - 0 RCSR: bit7 DONE = RX FIFO non-empty (RO); bit6 RIE (RW).
  - 1 RBUF: [7:0] RX FIFO head, 0 if empty; bit15 ERR=OVR; bit14 OVR (sticky).
  - 2 XCSR: bit7 READY = TX FIFO not full (RO); bit6 XIE (RW).
  - 3 XBUF: write-only, reads 0. A write of the low byte pushes [7:0]; if the FIFO is full the byte is dropped.
- Byte writes: wtbt_n low in the data phase means a byte write; a[0] selects the byte.
  - Odd-byte writes have no effect on any register.
  - Word writes use the low byte.
- Side-effect rules:
  - A write takes effect on the clk rply_oe rises.
  - An RBUF read pops one entry (if non-empty) and clears OVR on the clk din_n is sampled high after rply. Exactly once per bus cycle.
- RX: rx_valid pushes rx_data.
  - If the FIFO is full, the byte is dropped and OVR is set.
  - A push and a pop in the same clk both occur. When full, the pop frees the slot and the push is accepted.
- TX: tx_valid = TX FIFO non-empty; tx_data = head. Push and pop in the same clk both occur.
- Interrupts: rx_irq = RIE&DONE; tx_irq = XIE&READY. Combinational from registered state.
- Reset (rst_n or init_n low at clk):
  - FSM returns to IDLE.
  - Both FIFOs empty; RIE, XIE, OVR = 0.
  - Outputs: ad_oe=0, rply_oe=0, ad_out_n=16'hFFFF, tx_valid=0, irqs=0.
  - Reset in the middle of a bus cycle releases rply and ad immediately; the cycle is abandoned without side effects.

## Timing
- FSM states:
  - IDLE → ADDR on sync_n fall with hit. A non-hit stays in IDLE until sync_n rises.
  - ADDR → WAIT when din_n or dout_n is sampled low. Load the counter with RPLY_DLY.
  - WAIT: decrement each clk; → RPLY at 0. With RPLY_DLY=0 the state is passed in the same clk, so rply_oe rises on the clk after the strobe is sampled.
  - RPLY: rply_oe=1; → DONE when the active strobe is sampled high.
  - DONE: rply_oe=0; → IDLE when sync_n is sampled high, or → ADDR (DATI-DATO) if a new strobe arrives while sync_n is still low.
  - sync_n rising in any state → IDLE.
- Read data: ad_oe=1 and ad_out_n valid from the WAIT entry clk through the last RPLY clk. Data is stable at least 1 clk before rply_oe.
- Latency from strobe sample to rply_oe=1 is RPLY_DLY+1 clocks.
- Status bits reflect FIFO state registered at the clk before read data is launched; they are held stable while ad_oe=1.

## Test plan
- Reset, then read 177560/177564 → 0x0000 and 0x0080. tx_valid=0, irqs=0. rply_oe rises 2 clk after din_n low (RPLY_DLY=1).
- Word-write 0x0141 to 177566 with tx_ready=1 → one tx beat 0x41. Byte write to 177567 → no beat.
- Host pushes 0x55, 0xAA. Read RBUF twice → 0x0055 then 0x00AA. DONE falls after the second din_n release.
- With RX_DEPTH=4, push 5 bytes → RBUF reads 0xC0xx for the first byte (OVR|ERR), the next read has OVR=0, 4 bytes total recovered.
- Write RCSR=0x40, push a byte → rx_irq=1. Write XCSR=0x40 with the TX FIFO empty → tx_irq=1. Fill TX (4 writes, tx_ready=0) → tx_irq=0 and XCSR=0x0040.
- Assert rst_n=0 during RPLY → rply_oe=0 and ad_oe=0 the next clk. A pending RBUF pop does not occur. Access to 177570 → no rply (bus timeout).
